// File: rtl/bus_pkg.sv
// Shared constants for the data-bus responder: address map, timer register layout
// and timer FSM state encoding.
package bus_pkg;

    localparam int unsigned DM_WORDS = 3072;
    localparam logic [31:0] TC_BASE  = 32'h7F00;

    // Word offsets of the timer registers within the TC block
    localparam logic [1:0] TC_REG_CTRL   = 2'd0;
    localparam logic [1:0] TC_REG_PRESET = 2'd1;
    localparam logic [1:0] TC_REG_COUNT  = 2'd2;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    localparam logic [1:0] TC_IDLE = 2'd0;
    localparam logic [1:0] TC_LOAD = 2'd1;
    localparam logic [1:0] TC_CNT  = 2'd2;
    localparam logic [1:0] TC_INT  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = TC_IDLE,
        StLoad = TC_LOAD,
        StCnt  = TC_CNT,
        StInt  = TC_INT
    } tc_state_e;

endpackage

// File: rtl/tc_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, the count FSM,
// the pending flag and the masked interrupt output.
module tc_counter
    import bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tc_state_e   state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pending_q, pending_d;

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        mode_d    = mode_q;
        im_d      = im_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        case (state_q)
            StIdle: if (en_q) state_d = StLoad;
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!en_q) begin
                    state_d = StIdle;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Pending is raised on INT entry so a same-cycle CPU write can veto it
                    count_d   = '0;
                    state_d   = StInt;
                    pending_d = 1'b1;
                end
            end
            StInt: begin
                if (mode_q != MODE_RELOAD) en_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // CPU write overrides whatever the FSM wanted this cycle
        if (wr_en && (reg_sel == TC_REG_CTRL || reg_sel == TC_REG_PRESET)) begin
            if (reg_sel == TC_REG_CTRL) begin
                en_d   = wdata[CTRL_EN_BIT];
                mode_d = wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
                im_d   = wdata[CTRL_IM_BIT];
            end else begin
                preset_d = wdata;
            end
            count_d   = count_q;
            pending_d = 1'b0;
            state_d   = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            en_q      <= 1'b0;
            mode_q    <= 2'b00;
            im_q      <= 1'b0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            im_q      <= im_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            TC_REG_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
            TC_REG_PRESET: rdata = preset_q;
            TC_REG_COUNT:  rdata = count_q;
            default:       rdata = '0;
        endcase
    end

    assign irq = pending_q & im_q;

endmodule

// File: rtl/data_bus_responder.sv
// Slave end of the CPU data port: address decode, byte-enabled data memory,
// combinational read mux and the memory-mapped timer.
module data_bus_responder
    import bus_pkg::*;
#(
    parameter int unsigned DmWords = DM_WORDS,
    parameter logic [31:0] TcBase  = TC_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        irq
);

    localparam int unsigned DmAw   = $clog2(DmWords);
    localparam logic [29:0] TcWord = TcBase[31:2];

    logic [29:0]     word_idx;
    logic [DmAw-1:0] dm_idx;
    logic            dm_hit, tc_hit, dm_we;
    logic [1:0]      tc_sel;
    logic [31:0]     tc_rdata;
    logic [31:0]     dm_word_d;
    logic [31:0]     dm_q [DmWords];
    logic            unused_addr_lsb;

    assign word_idx        = m_data_addr[31:2];
    assign dm_idx          = word_idx[DmAw-1:0];
    assign dm_hit          = word_idx < 30'(DmWords);
    assign tc_hit          = (word_idx >= TcWord) && (word_idx < TcWord + 30'd3);
    assign tc_sel          = word_idx[1:0] - TcWord[1:0];
    assign dm_we           = dm_hit && (m_data_byteen != 4'b0000);
    assign unused_addr_lsb = ^m_data_addr[1:0];

    always_comb begin
        dm_word_d = dm_q[dm_idx];
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) dm_word_d[8*i +: 8] = m_data_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DmWords); i++) dm_q[i] <= '0;
        end else if (dm_we) begin
            dm_q[dm_idx] <= dm_word_d;
        end
    end

    tc_counter u_tc (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tc_hit && (m_data_byteen == 4'b1111)),
        .reg_sel (tc_sel),
        .wdata   (m_data_wdata),
        .rdata   (tc_rdata),
        .irq     (irq)
    );

    // Read sees pre-edge contents, so read-during-write returns the old word
    always_comb begin
        m_data_rdata = '0;
        if (dm_hit) begin
            m_data_rdata = dm_q[dm_idx];
        end else if (tc_hit) begin
            m_data_rdata = tc_rdata;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && dm_we) begin
            $display("%d@%h: *%h <= %h", $time, m_inst_addr, {word_idx, 2'b00}, dm_word_d);
        end
    end
`endif

endmodule
